// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: groups the pipeline-stage register addresses, control bits,
// stall/flush controls and forwarding selects exchanged with hazard_ctrl.
// Optional macro HAZARD_PERF_EN adds the stall_count / flush_count outputs.
interface hazard_ctrl_if;
  logic [4:0]  RS1_ID;
  logic [4:0]  RS2_ID;
  logic [4:0]  RS1_EX;
  logic [4:0]  RS2_EX;
  logic [4:0]  RD_EX;
  logic        RegWrite_EX;
  logic        MemToReg_EX;
  logic [4:0]  RD_MEM;
  logic        RegWrite_MEM;
  logic [4:0]  RD_WB;
  logic        RegWrite_WB;
  logic        BranchTaken_EX;
  logic        dmem_busy;
  logic        enable_PC;
  logic        enable_IF_ID;
  logic        enable_ID_EX;
  logic        flush_IF_ID;
  logic        flush_ID_EX;
  logic [1:0]  ForwardA_EX;
  logic [1:0]  ForwardB_EX;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count;
  logic [31:0] flush_count;
`endif

  // Pipeline side: drives stage info, consumes controls.
  modport master (
    output RS1_ID, RS2_ID, RS1_EX, RS2_EX, RD_EX, RegWrite_EX, MemToReg_EX,
           RD_MEM, RegWrite_MEM, RD_WB, RegWrite_WB, BranchTaken_EX, dmem_busy,
    input  enable_PC, enable_IF_ID, enable_ID_EX, flush_IF_ID, flush_ID_EX,
           ForwardA_EX, ForwardB_EX
`ifdef HAZARD_PERF_EN
    , input stall_count, flush_count
`endif
  );

  // Hazard controller side.
  modport slave (
    input  RS1_ID, RS2_ID, RS1_EX, RS2_EX, RD_EX, RegWrite_EX, MemToReg_EX,
           RD_MEM, RegWrite_MEM, RD_WB, RegWrite_WB, BranchTaken_EX, dmem_busy,
    output enable_PC, enable_IF_ID, enable_ID_EX, flush_IF_ID, flush_ID_EX,
           ForwardA_EX, ForwardB_EX
`ifdef HAZARD_PERF_EN
    , output stall_count, flush_count
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use bubble insertion, data-memory stall handling, branch
// squash and EX-stage operand forwarding for the 5-stage RV32 pipeline.
// Controls are Mealy (state + current inputs); forwarding is purely
// combinational. Optional macro HAZARD_PERF_EN adds stall/flush counters.
module hazard_ctrl #(
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 2
) (
  input  logic          clock,
  input  logic          reset,
  hazard_ctrl_if.slave  hif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BUBBLE   = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  state_e             state_q, state_d, eff_s;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lu_s;
  logic               en_pc_s, en_ifid_s, en_idex_s, fl_ifid_s, fl_idex_s;
  logic [1:0]         fwd_a_s, fwd_b_s;

  // Forward select for one source register: MEM result beats WB result.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       rw_mem,
    input logic [4:0] rd_mem,
    input logic       rw_wb,
    input logic [4:0] rd_wb
  );
    logic [1:0] sel;
    if (rw_mem && (rd_mem != 5'd0) && (rd_mem == rs)) begin
      sel = 2'b10;
    end else if (rw_wb && (rd_wb != 5'd0) && (rd_wb == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Next-state, bubble counter and Mealy control decode.
  always_comb begin
    lu_s = hif.MemToReg_EX && hif.RegWrite_EX && (hif.RD_EX != 5'd0) &&
           ((hif.RD_EX == hif.RS1_ID) || (hif.RD_EX == hif.RS2_ID));
    // Leaving MEM_WAIT behaves exactly like the state it returns to.
    if ((state_q == MEM_WAIT) && !hif.dmem_busy) begin
      eff_s = (cnt_q != '0) ? BUBBLE : RUN;
    end else begin
      eff_s = state_q;
    end
    state_d   = state_q;
    cnt_d     = cnt_q;
    en_pc_s   = 1'b1;
    en_ifid_s = 1'b1;
    en_idex_s = 1'b1;
    fl_ifid_s = 1'b0;
    fl_idex_s = 1'b0;
    if (hif.dmem_busy) begin
      // Freeze everything; cnt holds any pending bubbles.
      en_pc_s   = 1'b0;
      en_ifid_s = 1'b0;
      en_idex_s = 1'b0;
      state_d   = MEM_WAIT;
    end else begin
      state_d = eff_s;
      case (eff_s)
        RUN: begin
          if (hif.BranchTaken_EX) begin
            fl_ifid_s = 1'b1;
            fl_idex_s = 1'b1;
          end else if (lu_s) begin
            en_pc_s   = 1'b0;
            en_ifid_s = 1'b0;
            fl_idex_s = 1'b1;
            if (LOAD_LATENCY > 1) begin
              cnt_d   = CNT_W'(LOAD_LATENCY - 1);
              state_d = BUBBLE;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = RUN;
          end
        end
        BUBBLE: begin
          if (hif.BranchTaken_EX) begin
            // The stalled ID instruction is wrong-path: drop its bubbles.
            fl_ifid_s = 1'b1;
            fl_idex_s = 1'b1;
            cnt_d     = '0;
            state_d   = RUN;
          end else begin
            en_pc_s   = 1'b0;
            en_ifid_s = 1'b0;
            fl_idex_s = 1'b1;
            cnt_d     = cnt_q - CNT_W'(1);
            state_d   = (cnt_q == CNT_W'(1)) ? RUN : BUBBLE;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
    fwd_a_s = fwd_sel(hif.RS1_EX, hif.RegWrite_MEM, hif.RD_MEM, hif.RegWrite_WB, hif.RD_WB);
    fwd_b_s = fwd_sel(hif.RS2_EX, hif.RegWrite_MEM, hif.RD_MEM, hif.RegWrite_WB, hif.RD_WB);
    // Reset held low forces a free-running, non-forwarding pipeline.
    if (!reset) begin
      en_pc_s   = 1'b1;
      en_ifid_s = 1'b1;
      en_idex_s = 1'b1;
      fl_ifid_s = 1'b0;
      fl_idex_s = 1'b0;
      fwd_a_s   = 2'b00;
      fwd_b_s   = 2'b00;
    end else begin
      fwd_a_s   = fwd_a_s;
    end
  end

  // FSM state and bubble counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hif.enable_PC    = en_pc_s;
  assign hif.enable_IF_ID = en_ifid_s;
  assign hif.enable_ID_EX = en_idex_s;
  assign hif.flush_IF_ID  = fl_ifid_s;
  assign hif.flush_ID_EX  = fl_idex_s;
  assign hif.ForwardA_EX  = fwd_a_s;
  assign hif.ForwardB_EX  = fwd_b_s;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Performance counter increments; both wrap naturally at 2^32.
  always_comb begin
    if (!en_pc_s) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (fl_ifid_s) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hif.stall_count = stall_cnt_q;
  assign hif.flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: drives two controllers (LOAD_LATENCY 1 and 3) with identical
// stimulus and compares them every cycle against a state-free behavioural
// model that tracks only the number of bubbles still owed.
module tb_hazard_ctrl;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic       rw_ex, m2r_ex, rw_mem, rw_wb, br, busy;

  hazard_ctrl_if if1 ();
  hazard_ctrl_if if3 ();

  assign if1.RS1_ID = rs1_id;  assign if3.RS1_ID = rs1_id;
  assign if1.RS2_ID = rs2_id;  assign if3.RS2_ID = rs2_id;
  assign if1.RS1_EX = rs1_ex;  assign if3.RS1_EX = rs1_ex;
  assign if1.RS2_EX = rs2_ex;  assign if3.RS2_EX = rs2_ex;
  assign if1.RD_EX = rd_ex;    assign if3.RD_EX = rd_ex;
  assign if1.RegWrite_EX = rw_ex;   assign if3.RegWrite_EX = rw_ex;
  assign if1.MemToReg_EX = m2r_ex;  assign if3.MemToReg_EX = m2r_ex;
  assign if1.RD_MEM = rd_mem;  assign if3.RD_MEM = rd_mem;
  assign if1.RegWrite_MEM = rw_mem; assign if3.RegWrite_MEM = rw_mem;
  assign if1.RD_WB = rd_wb;    assign if3.RD_WB = rd_wb;
  assign if1.RegWrite_WB = rw_wb;   assign if3.RegWrite_WB = rw_wb;
  assign if1.BranchTaken_EX = br;   assign if3.BranchTaken_EX = br;
  assign if1.dmem_busy = busy;      assign if3.dmem_busy = busy;

  hazard_ctrl #(.LOAD_LATENCY(1), .CNT_W(2)) dut1 (.clock(clock), .reset(reset), .hif(if1));
  hazard_ctrl #(.LOAD_LATENCY(3), .CNT_W(2)) dut3 (.clock(clock), .reset(reset), .hif(if3));

  // {enable_PC, enable_IF_ID, enable_ID_EX, flush_IF_ID, flush_ID_EX, FwdA, FwdB}
  wire [8:0] out1 = {if1.enable_PC, if1.enable_IF_ID, if1.enable_ID_EX, if1.flush_IF_ID,
                     if1.flush_ID_EX, if1.ForwardA_EX, if1.ForwardB_EX};
  wire [8:0] out3 = {if3.enable_PC, if3.enable_IF_ID, if3.enable_ID_EX, if3.flush_IF_ID,
                     if3.flush_ID_EX, if3.ForwardA_EX, if3.ForwardB_EX};

  int passes = 0;
  int checks = 0;
  int rem1 = 0;
  int rem3 = 0;
  logic [8:0] e1, e3;
  logic [31:0] st1 = 32'd0, fl1 = 32'd0, st3 = 32'd0, fl3 = 32'd0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (rw_mem && rd_mem != 5'd0 && rd_mem == rs) return 2'b10;
    if (rw_wb && rd_wb != 5'd0 && rd_wb == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic load_use();
    return m2r_ex && rw_ex && rd_ex != 5'd0 && (rd_ex == rs1_id || rd_ex == rs2_id);
  endfunction

  // Expected outputs given how many bubbles are still owed.
  function automatic logic [8:0] model_out(input int rem);
    logic [4:0] ctl;
    if (!reset) return 9'b111000000;
    if (busy) ctl = 5'b00000;
    else if (br) ctl = 5'b11111;
    else if (rem > 0 || load_use()) ctl = 5'b00101;
    else ctl = 5'b11100;
    return {ctl, fwd(rs1_ex), fwd(rs2_ex)};
  endfunction

  function automatic int model_next(input int lat, input int rem);
    if (!reset) return 0;
    if (busy) return rem;
    if (br) return 0;
    if (rem > 0) return rem - 1;
    if (load_use()) return lat - 1;
    return 0;
  endfunction

  task automatic clear_inputs();
    {rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb} = '0;
    {rw_ex, m2r_ex, rw_mem, rw_wb, br, busy} = '0;
  endtask

  // Compare both DUTs against the model mid-cycle.
  task automatic check_now();
    @(negedge clock);
    e1 = model_out(rem1);
    e3 = model_out(rem3);
    chk("outs_L1", 32'(out1), 32'(e1));
    chk("outs_L3", 32'(out3), 32'(e3));
`ifdef HAZARD_PERF_EN
    chk("stall_L1", if1.stall_count, st1);
    chk("flush_L1", if1.flush_count, fl1);
    chk("stall_L3", if3.stall_count, st3);
    chk("flush_L3", if3.flush_count, fl3);
`endif
  endtask

  // Advance the model across the rising edge; inputs change #1 later.
  task automatic advance();
    @(posedge clock);
    if (!reset) begin
      st1 = 32'd0; fl1 = 32'd0; st3 = 32'd0; fl3 = 32'd0;
    end else begin
      st1 = st1 + 32'(!e1[8]); fl1 = fl1 + 32'(e1[5]);
      st3 = st3 + 32'(!e3[8]); fl3 = fl3 + 32'(e3[5]);
    end
    rem1 = model_next(1, rem1);
    rem3 = model_next(3, rem3);
    #1;
  endtask

  task automatic set_load_use();
    clear_inputs();
    m2r_ex = 1'b1; rw_ex = 1'b1; rd_ex = 5'd3; rs2_id = 5'd3;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    #1;
    chk("reset_outs", 32'(out3), 32'(9'b111000000));
    rw_mem = 1'b1; rd_mem = 5'd5; rs1_ex = 5'd5;
    #1;
    chk("reset_no_fwd", 32'(if1.ForwardA_EX), 32'(2'b00));
    @(posedge clock); #1;
    reset = 1'b1;

    // Forwarding: MEM beats WB, then WB alone.
    clear_inputs();
    rw_mem = 1'b1; rd_mem = 5'd5; rw_wb = 1'b1; rd_wb = 5'd5; rs1_ex = 5'd5; rs2_ex = 5'd0;
    check_now();
    chk("fwdA_mem", 32'(if1.ForwardA_EX), 32'(2'b10));
    chk("fwdB_none", 32'(if1.ForwardB_EX), 32'(2'b00));
    advance();
    rw_mem = 1'b0;
    check_now();
    chk("fwdA_wb", 32'(if1.ForwardA_EX), 32'(2'b01));
    advance();

    // Load-use: one bubble for latency 1, three for latency 3.
    set_load_use();
    check_now();
    chk("lu_L1_bubble", 32'(out1), 32'(9'b001010000));
    advance();
    clear_inputs();
    check_now();
    chk("lu_L1_done", 32'(out1), 32'(9'b111000000));
    chk("lu_L3_b2", 32'(if3.enable_PC), 32'(1'b0));
    advance();
    check_now();
    chk("lu_L3_b3", 32'(out3), 32'(9'b001010000));
    advance();
    check_now();
    chk("lu_L3_done", 32'(if3.enable_PC), 32'(1'b1));
    advance();

    // Memory stall during the second bubble freezes, then resumes bubbles.
    set_load_use();
    check_now();
    advance();
    clear_inputs();
    busy = 1'b1;
    check_now();
    chk("wait_freeze", 32'(out3), 32'(9'b000000000));
    advance();
    check_now();
    advance();
    busy = 1'b0;
    check_now();
    chk("wait_b2", 32'(out3), 32'(9'b001010000));
    advance();
    check_now();
    chk("wait_b3", 32'(if3.flush_ID_EX), 32'(1'b1));
    advance();
    check_now();
    chk("wait_done", 32'(if3.enable_PC), 32'(1'b1));
    advance();

    // Taken branch beats load-use.
    set_load_use();
    br = 1'b1;
    check_now();
    chk("br_over_lu", 32'(out3), 32'(9'b111110000));
    advance();
    clear_inputs();
    check_now();
    chk("br_no_stall", 32'(if3.enable_PC), 32'(1'b1));
    advance();

    // Load to x0 never stalls.
    clear_inputs();
    m2r_ex = 1'b1; rw_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0;
    check_now();
    chk("x0_no_stall", 32'(out1 & out3), 32'(9'b111000000));
    advance();

    // Async reset in the middle of a bubble run.
    set_load_use();
    check_now();
    advance();
    clear_inputs();
    check_now();
    chk("pre_reset_bubble", 32'(if3.enable_PC), 32'(1'b0));
    reset = 1'b0;
    #1;
    chk("reset_mid_bubble", 32'(out3), 32'(9'b111000000));
    advance();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_now();
      chk("post_reset_run", 32'(if3.enable_PC), 32'(1'b1));
      advance();
    end

    // Randomized traffic over a small register range to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      rs1_id = 5'($urandom_range(0, 3)); rs2_id = 5'($urandom_range(0, 3));
      rs1_ex = 5'($urandom_range(0, 3)); rs2_ex = 5'($urandom_range(0, 3));
      rd_ex  = 5'($urandom_range(0, 3)); rd_mem = 5'($urandom_range(0, 3));
      rd_wb  = 5'($urandom_range(0, 3));
      rw_ex  = 1'($urandom_range(0, 1)); m2r_ex = 1'($urandom_range(0, 1));
      rw_mem = 1'($urandom_range(0, 1)); rw_wb  = 1'($urandom_range(0, 1));
      br     = ($urandom_range(0, 7) == 0);
      busy   = ($urandom_range(0, 5) == 0);
      reset  = ($urandom_range(0, 199) != 0);
      check_now();
      advance();
    end
    reset = 1'b1;

`ifdef HAZARD_PERF_EN
    // Two load-use stalls plus one taken branch from a fresh reset.
    reset = 1'b0;
    clear_inputs();
    advance();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin clear_inputs(); br = 1'b1; end
      else set_load_use();
      check_now();
      advance();
      clear_inputs();
      check_now();
      advance();
    end
    check_now();
    chk("perf_stall", if1.stall_count, 32'd2);
    chk("perf_flush", if1.flush_count, 32'd1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and forwarding controller for the 5-stage RV32 core. It consumes register addresses and control bits from the ID, EX, MEM and WB stages. It drives the enable and flush inputs of the PC, IF/ID and ID/EX pipeline registers, and the EX-stage operand forwarding selects. A small FSM inserts load-use bubbles, waits out data-memory stalls and squashes wrong-path instructions on a taken branch.

Parameters:
LOAD_LATENCY, 1, number of bubbles inserted on a load-use hazard (range 1..3).
CNT_W, 2, width of the bubble counter; must hold LOAD_LATENCY.

Ports:
clock  input  1  core clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset.
RS1_ID  input  5  rs1 of the instruction in ID (instr[19:15]).
RS2_ID  input  5  rs2 of the instruction in ID (instr[24:20]).
RS1_EX  input  5  rs1 held in ID/EX.
RS2_EX  input  5  rs2 held in ID/EX.
RD_EX  input  5  rd held in ID/EX.
RegWrite_EX  input  1  EX instruction writes rd.
MemToReg_EX  input  1  EX instruction is a load.
RD_MEM  input  5  rd in EX/MEM.
RegWrite_MEM  input  1  MEM instruction writes rd.
RD_WB  input  5  rd in MEM/WB.
RegWrite_WB  input  1  WB instruction writes rd.
BranchTaken_EX  input  1  branch in EX resolved taken.
dmem_busy  input  1  data memory cannot complete this cycle.
enable_PC  output  1  PC register load enable.
enable_IF_ID  output  1  IF/ID load enable.
enable_ID_EX  output  1  ID/EX load enable.
flush_IF_ID  output  1  IF/ID loads zeros (NOP) on next edge.
flush_ID_EX  output  1  ID/EX loads zeros (bubble) on next edge.
ForwardA_EX  output  2  ALU operand A select: 00 regfile, 10 EX/MEM result, 01 WB result.
ForwardB_EX  output  2  ALU operand B select, same encoding.

Behaviour:
- Reset (reset=0, async): state=RUN, cnt=0. While reset is low, outputs are forced to enables=1, flushes=0, forwards=00.
- Forwarding is combinational with no latency:
  - ForwardA_EX=10 if RegWrite_MEM && RD_MEM!=0 && RD_MEM==RS1_EX.
  - Otherwise ForwardA_EX=01 if RegWrite_WB && RD_WB!=0 && RD_WB==RS1_EX.
  - Otherwise ForwardA_EX=00. MEM beats WB. ForwardB_EX uses RS2_EX the same way.
- Load-use detect: lu = MemToReg_EX && RegWrite_EX && RD_EX!=0 && (RD_EX==RS1_ID || RD_EX==RS2_ID).
- FSM states: RUN, BUBBLE, MEM_WAIT. Outputs are Mealy, decoded from state and inputs.
- Priority in every state: dmem_busy > BranchTaken_EX > lu.
- RUN:
  - dmem_busy: all three enables=0, flushes=0, next state MEM_WAIT, cnt unchanged.
  - BranchTaken_EX: enables=1, flush_IF_ID=1, flush_ID_EX=1, stay in RUN.
  - lu: enable_PC=0, enable_IF_ID=0, enable_ID_EX=1, flush_ID_EX=1. If LOAD_LATENCY>1, cnt<=LOAD_LATENCY-1 and next state BUBBLE; otherwise stay in RUN.
  - None of the above: enables=1, flushes=0.
- BUBBLE:
  - Outputs as for lu, regardless of lu.
  - cnt decrements by 1 each cycle. Leave for RUN on the cycle cnt==1, after which cnt=0.
  - dmem_busy preempts: MEM_WAIT outputs apply and cnt freezes.
- MEM_WAIT:
  - All enables=0, flushes=0.
  - On the first cycle dmem_busy=0: return to BUBBLE if cnt!=0, else RUN. That cycle's outputs follow the target state's rules.
- A flush with its enable low has no effect; ID/EX is never flushed while enable_ID_EX=0.
- rd=x0 never triggers a stall or a forward.
- An asynchronous reset mid-BUBBLE or mid-MEM_WAIT returns the FSM to RUN immediately and drops any pending bubbles.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs stall_count[31:0] and flush_count[31:0], both reset to 0.
  - stall_count increments each cycle enable_PC=0.
  - flush_count increments each cycle flush_IF_ID=1.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. RegWrite_MEM=1, RD_MEM=5, RegWrite_WB=1, RD_WB=5, RS1_EX=5, RS2_EX=0 -> ForwardA_EX=10, ForwardB_EX=00. Then RegWrite_MEM=0 -> ForwardA_EX=01.
2. LOAD_LATENCY=1; MemToReg_EX=1, RegWrite_EX=1, RD_EX=3, RS2_ID=3 for one cycle -> one cycle of enable_PC=0, enable_IF_ID=0, flush_ID_EX=1, then all enables=1.
3. LOAD_LATENCY=3; same hazard -> exactly 3 consecutive bubble cycles, then RUN. Repeat with dmem_busy=1 for 2 cycles during the 2nd bubble -> 2 freeze cycles, then the remaining bubbles, for 3 bubbles total.
4. BranchTaken_EX=1 together with lu=1 -> flush_IF_ID=1, flush_ID_EX=1, enables=1, no stall.
5. RD_EX=0 load with RS1_ID=0 -> no stall. Assert reset low mid-BUBBLE -> enables=1 immediately and no further bubbles after release.
6. With HAZARD_PERF_EN: 2 load-use stalls plus 1 taken branch -> stall_count=2, flush_count=1.
